// File: rtl/pll_reconfig_ctl.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctl
//
// Dynamic-reconfiguration controller for the Tang 138K PLL. Software fills a
// shadow register file over an Avalon-MM management port and then writes
// START. The controller streams only the dirty shadow words to the PLL
// configuration port, pulses pll_reset, and waits for lock with a timeout.
//
// Ports:
//   mgmt_clk, mgmt_reset          sole clock, synchronous active-high reset
//   mgmt_read/mgmt_write          bus strobes
//   mgmt_address/mgmt_writedata   bus address and write data
//   mgmt_readdata                 combinational read mux, 0 when not reading
//   mgmt_waitrequest              stall while busy in waitrequest mode
//   pll_cfg_req/addr/data         config word offered to the PLL
//   pll_cfg_ack                   PLL accepted the offered word
//   pll_reset                     PLL reset pulse, RST_CYCLES long
//   pll_lock                      asynchronous PLL lock, synchronised here
//
// Handshake (pll_cfg_req / pll_cfg_ack): a word transfers on the clock edge
// where req and ack are both high. While req is high, addr and data are held
// stable. req is only raised one cycle after entering SEND and drops the
// cycle after the transfer, so two words never go back to back.
//
// Register map: 0x00 MODE (bit0: 0 stall, 1 polling), 0x01 STATUS
// {error, locked, busy}, 0x02 START (write only), 0x08.. SHADOW[i].
// ---------------------------------------------------------------------------
module pll_reconfig_ctl #(
  parameter int NUM_REGS     = 16,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic              mgmt_clk,
  input  logic              mgmt_reset,
  input  logic              mgmt_read,
  input  logic              mgmt_write,
  input  logic [ADDR_W-1:0] mgmt_address,
  input  logic [DATA_W-1:0] mgmt_writedata,
  output logic [DATA_W-1:0] mgmt_readdata,
  output logic              mgmt_waitrequest,
  output logic              pll_cfg_req,
  output logic [ADDR_W-1:0] pll_cfg_addr,
  output logic [DATA_W-1:0] pll_cfg_data,
  input  logic              pll_cfg_ack,
  output logic              pll_reset,
  input  logic              pll_lock
);

  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int MAX_CNT = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [ADDR_W-1:0] A_MODE   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SHADOW = ADDR_W'(8);
  // One bit wider so a shadow window ending exactly at 2^ADDR_W still compares.
  localparam logic [ADDR_W:0]   SHADOW_END = (ADDR_W + 1)'(8 + NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND,
    ST_RST,
    ST_WAIT_LOCK
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shadow [NUM_REGS];
  logic [NUM_REGS-1:0] dirty;
  logic                mode;
  logic                error;
  logic                lock_meta;
  logic                lock_sync;

  logic                busy;
  logic                sel_shadow;
  logic [IDX_W-1:0]    sh_idx;
  logic                wr_en;
  logic                shadow_wr;
  logic                start_wr;
  logic                mode_wr;

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  assign sel_shadow = (mgmt_address >= A_SHADOW) && ({1'b0, mgmt_address} < SHADOW_END);
  assign sh_idx     = IDX_W'(mgmt_address - A_SHADOW);

  // In stall mode every access waits until the FSM is back in IDLE; the
  // access then completes in that first IDLE cycle.
  assign mgmt_waitrequest = (mgmt_read | mgmt_write) & ~mode & busy;

  assign wr_en     = mgmt_write & ~mgmt_waitrequest;
  // In polling mode shadow and START writes during a sequence are dropped.
  assign shadow_wr = wr_en & ~busy & sel_shadow;
  assign start_wr  = wr_en & ~busy & (mgmt_address == A_START);
  assign mode_wr   = wr_en & (mgmt_address == A_MODE);

  always_comb begin
    mgmt_readdata = '0;
    if (mgmt_read) begin
      if (mgmt_address == A_MODE) begin
        mgmt_readdata[0] = mode;
      end else if (mgmt_address == A_STATUS) begin
        mgmt_readdata[2:0] = {error, lock_sync, busy};
      end else if (sel_shadow) begin
        mgmt_readdata = shadow[sh_idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shadow register file and mode bit
  // ---------------------------------------------------------------------
  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (shadow_wr) begin
      shadow[sh_idx] <= mgmt_writedata;
    end
  end

  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      mode <= 1'b0;
    end else if (mode_wr) begin
      mode <= mgmt_writedata[0];
    end
  end

  // pll_lock is asynchronous: two-flop synchroniser.
  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer. cnt is shared: RST pulse length, then lock-wait time.
  // ---------------------------------------------------------------------
  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      dirty        <= '0;
      error        <= 1'b0;
      pll_cfg_req  <= 1'b0;
      pll_cfg_addr <= '0;
      pll_cfg_data <= '0;
      pll_reset    <= 1'b0;
    end else begin
      // Shadow writes only happen in IDLE, so they never race an ack clear.
      if (shadow_wr) begin
        dirty[sh_idx] <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            state <= ST_SCAN;
            idx   <= '0;
            error <= 1'b0;
          end
        end

        ST_SCAN: begin
          if (dirty[idx]) begin
            state        <= ST_SEND;
            pll_cfg_addr <= ADDR_W'(idx);
            pll_cfg_data <= shadow[idx];
          end else if (idx == LAST_IDX) begin
            state     <= ST_RST;
            pll_reset <= 1'b1;
            cnt       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_SEND: begin
          if (!pll_cfg_req) begin
            pll_cfg_req <= 1'b1;
          end else if (pll_cfg_ack) begin
            pll_cfg_req <= 1'b0;
            dirty[idx]  <= 1'b0;
            if (idx == LAST_IDX) begin
              state     <= ST_RST;
              pll_reset <= 1'b1;
              cnt       <= '0;
            end else begin
              state <= ST_SCAN;
              idx   <= idx + 1'b1;
            end
          end
        end

        ST_RST: begin
          if (cnt == RST_LAST) begin
            state     <= ST_WAIT_LOCK;
            pll_reset <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_sync) begin
            state <= ST_IDLE;
          end else if (cnt == LOCK_LAST) begin
            state <= ST_IDLE;
            error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctl.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_ctl
//
// Directed bench: a vector table for plain register accesses, then
// hand-written sequences for reconfiguration, forced relock, lock timeout,
// polling mode, stall mode and reset in the middle of SEND. A small PLL
// responder acks words and raises lock a fixed time after pll_reset.
// ---------------------------------------------------------------------------
module tb_pll_reconfig_ctl;

  localparam int NUM_REGS     = 16;
  localparam int ADDR_W       = 6;
  localparam int DATA_W       = 32;
  localparam int RST_CYCLES   = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int LOCK_DLY     = 20;
  localparam int STALL_MAX    = 2000;
  localparam int XW           = ADDR_W + DATA_W;

  logic              clk;
  logic              mgmt_reset;
  logic              mgmt_read;
  logic              mgmt_write;
  logic [ADDR_W-1:0] mgmt_address;
  logic [DATA_W-1:0] mgmt_writedata;
  logic [DATA_W-1:0] mgmt_readdata;
  logic              mgmt_waitrequest;
  logic              pll_cfg_req;
  logic [ADDR_W-1:0] pll_cfg_addr;
  logic [DATA_W-1:0] pll_cfg_data;
  logic              pll_cfg_ack;
  logic              pll_reset;
  logic              pll_lock;

  pll_reconfig_ctl #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .mgmt_clk        (clk),
    .mgmt_reset      (mgmt_reset),
    .mgmt_read       (mgmt_read),
    .mgmt_write      (mgmt_write),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_cfg_req     (pll_cfg_req),
    .pll_cfg_addr    (pll_cfg_addr),
    .pll_cfg_data    (pll_cfg_data),
    .pll_cfg_ack     (pll_cfg_ack),
    .pll_reset       (pll_reset),
    .pll_lock        (pll_lock)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- PLL responder ----------------
  int ack_lat = 3;
  bit ack_en  = 1'b1;
  int ack_cnt = 0;
  bit lock_en = 1'b0;
  int lock_cnt = 0;

  initial begin
    pll_cfg_ack = 1'b0;
    pll_lock    = 1'b0;
  end

  always @(negedge clk) begin
    if (pll_cfg_ack) begin
      pll_cfg_ack = 1'b0;
      ack_cnt     = 0;
    end else if (pll_cfg_req && ack_en) begin
      ack_cnt++;
      if (ack_cnt >= ack_lat) pll_cfg_ack = 1'b1;
    end else begin
      ack_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (pll_reset) begin
      pll_lock = 1'b0;
      lock_cnt = 0;
    end else if (lock_en && !pll_lock) begin
      lock_cnt++;
      if (lock_cnt >= LOCK_DLY) pll_lock = 1'b1;
    end
  end

  // ---------------- monitor + scoreboard ----------------
  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] got_q[$];
  int            rst_q[$];
  logic [XW-1:0] cur_ad = '0;
  int req_rises = 0;
  int stab_err  = 0;
  int rst_len   = 0;
  bit req_prev  = 1'b0;
  bit rst_prev  = 1'b0;

  always @(negedge clk) begin
    if (pll_cfg_req && !req_prev) begin
      req_rises++;
      cur_ad = {pll_cfg_addr, pll_cfg_data};
      got_q.push_back(cur_ad);
    end else if (pll_cfg_req && ({pll_cfg_addr, pll_cfg_data} != cur_ad)) begin
      stab_err++;
    end
    req_prev = pll_cfg_req;
    if (pll_reset) begin
      rst_len++;
    end else if (rst_prev) begin
      rst_q.push_back(rst_len);
      rst_len = 0;
    end
    rst_prev = pll_reset;
  end

  task automatic check_xfers(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, " word"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_rst_pulse(input string tag);
    check({tag, " rst pulses"}, rst_q.size(), 1);
    check({tag, " rst len"}, (rst_q.size() > 0) ? rst_q[0] : -1, RST_CYCLES);
    rst_q.delete();
  endtask

  // ---------------- bus driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output int waited);
    waited       = 0;
    d            = '0;
    mgmt_address = a;
    mgmt_read    = 1'b1;
    for (int i = 0; i < STALL_MAX; i++) begin
      @(negedge clk);
      if (!mgmt_waitrequest) begin
        d = mgmt_readdata;
        @(posedge clk); #1;
        mgmt_read = 1'b0;
        return;
      end
      waited++;
      @(posedge clk); #1;
    end
    tests++;
    fails++;
    $display("FAIL bus_read stall timeout: addr 0x%0h still waiting after %0d cycles", a, waited);
    mgmt_read = 1'b0;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int waited);
    waited         = 0;
    mgmt_address   = a;
    mgmt_writedata = d;
    mgmt_write     = 1'b1;
    for (int i = 0; i < STALL_MAX; i++) begin
      @(negedge clk);
      if (!mgmt_waitrequest) begin
        @(posedge clk); #1;
        mgmt_write = 1'b0;
        return;
      end
      waited++;
      @(posedge clk); #1;
    end
    tests++;
    fails++;
    $display("FAIL bus_write stall timeout: addr 0x%0h still waiting after %0d cycles", a, waited);
    mgmt_write = 1'b0;
  endtask

  task automatic do_reset();
    mgmt_reset = 1'b1;
    @(posedge clk); #1;
    mgmt_reset = 1'b0;
  endtask

  // Polling-mode wait for busy to clear; returns the final STATUS.
  task automatic wait_idle_poll(output logic [DATA_W-1:0] st);
    int w;
    st = '0;
    for (int i = 0; i < STALL_MAX; i++) begin
      bus_read(ADDR_W'(1), st, w);
      if (st[0] == 1'b0) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_idle_poll: busy still 1, status 0x%0h", st);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    logic [DATA_W-1:0] d;
    int                w;
    int                r0;
    int                wl;
    bit                seen_rst;
    bit                saw_req;
    bit                wr_stall;

    mgmt_reset     = 1'b1;
    mgmt_read      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;

    vecs[0]  = '{1'b0, 6'h01, 32'h0,         32'h0};         // STATUS idle
    vecs[1]  = '{1'b0, 6'h00, 32'h0,         32'h0};         // MODE reset
    vecs[2]  = '{1'b1, 6'h0B, 32'hA5A5_0003, 32'h0};         // SHADOW[3]
    vecs[3]  = '{1'b0, 6'h0B, 32'h0,         32'hA5A5_0003};
    vecs[4]  = '{1'b0, 6'h3F, 32'h0,         32'h0};         // unmapped
    vecs[5]  = '{1'b1, 6'h3F, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, 6'h3F, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 6'h00, 32'hFFFF_FFFF, 32'h0};         // MODE=1
    vecs[8]  = '{1'b0, 6'h00, 32'h0,         32'h1};
    vecs[9]  = '{1'b1, 6'h00, 32'h0,         32'h0};         // MODE=0
    vecs[10] = '{1'b0, 6'h00, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 6'h08, 32'h0,         32'h0};         // SHADOW[0]
    vecs[12] = '{1'b1, 6'h17, 32'h1234_5678, 32'h0};         // SHADOW[15]
    vecs[13] = '{1'b0, 6'h17, 32'h0,         32'h1234_5678};
    vecs[14] = '{1'b0, 6'h18, 32'h0,         32'h0};         // past last shadow
    vecs[15] = '{1'b0, 6'h02, 32'h0,         32'h0};         // START reads 0

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    mgmt_reset = 1'b0;
    @(negedge clk);
    check("rst readdata",    mgmt_readdata,    0);
    check("rst waitrequest", mgmt_waitrequest, 0);
    check("rst req",         pll_cfg_req,      0);
    check("rst cfg_addr",    pll_cfg_addr,     0);
    check("rst cfg_data",    pll_cfg_data,     0);
    check("rst pll_reset",   pll_reset,        0);
    @(posedge clk); #1;

    // ---- register access table ----
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data, w);
      end else begin
        bus_read(vecs[i].addr, d, w);
        check($sformatf("vec%0d read 0x%0h", i, vecs[i].addr), d, vecs[i].exp);
      end
    end

    // ---- two dirty words, ack after 3 cycles, lock 20 cycles after RST ----
    do_reset();
    lock_en = 1'b1;
    ack_lat = 3;
    bus_write(6'h0A, 32'h2222_0002, w);
    bus_write(6'h11, 32'h9999_0009, w);
    got_q.delete();
    rst_q.delete();
    exp_q.push_back({6'd2, 32'h2222_0002});
    exp_q.push_back({6'd9, 32'h9999_0009});
    r0 = req_rises;
    bus_write(6'h02, 32'h0, w);
    bus_read(6'h01, d, w);
    check("seq status", d, 32'h2);
    check("seq stalled", w > 0, 1);
    check("seq req rises", req_rises - r0, 2);
    check_xfers("seq xfer");
    check_rst_pulse("seq");
    bus_read(6'h11, d, w);
    check("seq shadow9", d, 32'h9999_0009);

    // ---- forced relock: nothing dirty ----
    r0 = req_rises;
    bus_write(6'h02, 32'h0, w);
    bus_read(6'h01, d, w);
    check("relock status", d, 32'h2);
    check("relock req rises", req_rises - r0, 0);
    check_rst_pulse("relock");

    // ---- lock timeout, observed in polling mode ----
    lock_en = 1'b0;
    bus_write(6'h00, 32'h1, w);
    bus_write(6'h02, 32'h0, w);
    mgmt_address = 6'h01;
    mgmt_read    = 1'b1;
    seen_rst     = 1'b0;
    wl           = 0;
    wr_stall     = 1'b0;
    d            = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mgmt_waitrequest) wr_stall = 1'b1;
      d = mgmt_readdata;
      if (pll_reset) seen_rst = 1'b1;
      else if (seen_rst && d[0]) wl++;
      @(posedge clk); #1;
      if (!d[0]) break;
    end
    mgmt_read = 1'b0;
    check("timeout wait cycles", wl, LOCK_TIMEOUT);
    check("timeout status", d, 32'h4);
    check("poll no stall", wr_stall, 0);
    rst_q.delete();

    // ---- new START clears error; polling-mode write dropped ----
    lock_en = 1'b1;
    bus_write(6'h02, 32'h0, w);
    bus_read(6'h01, d, w);
    check("restart status", d, 32'h1);
    check("restart read wait", w, 0);
    bus_write(6'h0D, 32'h55, w);
    check("poll shadow write wait", w, 0);
    bus_read(6'h0D, d, w);
    check("poll shadow5 dropped", d, 32'h0);
    bus_read(6'h01, d, w);
    check("poll busy bit", d[0], 1);
    wait_idle_poll(d);
    check("poll final status", d, 32'h2);
    r0 = req_rises;
    bus_write(6'h02, 32'h0, w);
    wait_idle_poll(d);
    check("poll shadow5 not dirty", req_rises - r0, 0);
    rst_q.delete();

    // ---- stall mode: read during busy waits for IDLE ----
    bus_write(6'h00, 32'h0, w);
    bus_write(6'h02, 32'h0, w);
    bus_read(6'h00, d, w);
    check("stall mode read", d, 32'h0);
    check("stall length", w >= NUM_REGS + RST_CYCLES, 1);
    bus_read(6'h01, d, w);
    check("stall after status", d, 32'h2);
    rst_q.delete();

    // ---- reset while SEND with ack withheld ----
    bus_write(6'h0C, 32'h4444_0004, w);
    ack_en = 1'b0;
    bus_write(6'h02, 32'h0, w);
    saw_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pll_cfg_req) begin
        saw_req = 1'b1;
        break;
      end
    end
    check("midsend req seen", saw_req, 1);
    @(posedge clk); #1;
    mgmt_reset = 1'b1;
    @(posedge clk); #1;
    mgmt_reset = 1'b0;
    @(negedge clk);
    check("midsend req dropped", pll_cfg_req, 0);
    check("midsend pll_reset", pll_reset, 0);
    check("midsend cfg_addr", pll_cfg_addr, 0);
    @(posedge clk); #1;
    ack_en = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus_read(ADDR_W'(8 + i), d, w);
      check($sformatf("midsend shadow%0d", i), d, 32'h0);
    end
    bus_read(6'h00, d, w);
    check("midsend mode", d, 32'h0);
    got_q.delete();
    rst_q.delete();
    r0 = req_rises;
    bus_write(6'h02, 32'h0, w);
    bus_read(6'h01, d, w);
    check("midsend restart status", d, 32'h2);
    check("midsend no words", req_rises - r0, 0);
    check_rst_pulse("midsend");
    check("req stability", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctl.md
# pll_reconfig_ctl

Parametrised dynamic-reconfiguration controller for the Tang 138K PLL, sitting between the MiSTer-style Avalon-MM management bus and the Gowin PLL configuration port. Software writes a shadow register file, then a START command. The block streams only the modified (dirty) registers to the PLL over a req/ack handshake, pulses PLL reset, and waits for lock with a timeout. A mode bit selects stall-the-bus or polling behaviour while busy.

## Interface
Parameters:
- NUM_REGS, 16, number of shadow config registers; must be ≤ 2^ADDR_W − 8.
- ADDR_W, 6, management address width.
- DATA_W, 32, management and PLL config data width.
- RST_CYCLES, 8, pll_reset pulse length in cycles (≥ 1).
- LOCK_TIMEOUT, 4096, cycles to wait for lock before flagging an error (≥ 1).

Ports:
- mgmt_clk  in  1  sole clock.
- mgmt_reset  in  1  reset; synchronous, active-high.
- mgmt_read  in  1  read strobe.
- mgmt_write  in  1  write strobe.
- mgmt_address  in  ADDR_W  register address.
- mgmt_writedata  in  DATA_W  write data.
- mgmt_readdata  out  DATA_W  read data.
- mgmt_waitrequest  out  1  bus stall.
- pll_cfg_req  out  1  config word valid.
- pll_cfg_addr  out  ADDR_W  shadow index being sent.
- pll_cfg_data  out  DATA_W  config word.
- pll_cfg_ack  in  1  PLL accepted the word.
- pll_reset  out  1  PLL reset.
- pll_lock  in  1  PLL lock; asynchronous.

## Operation
- Register map:
  - 0x00 MODE (RW): bit0 0 = waitrequest mode, 1 = polling mode.
  - 0x01 STATUS (RO): bit0 busy, bit1 locked (synchronised pll_lock), bit2 timeout error (sticky).
  - 0x02 START (WO): any write starts a sequence.
  - 0x08..0x08+NUM_REGS−1 SHADOW[i] (RW).
  - All other addresses read 0; writes to them are ignored.
- A SHADOW write sets dirty[i]. dirty[i] clears when that word is acked.
- FSM states:
  - IDLE: a START write goes to SCAN, with idx=0, busy=1, and the error bit cleared.
  - SCAN: one index per cycle. If dirty[idx], go to SEND. Otherwise, if idx=NUM_REGS−1, go to RST; otherwise increment idx.
  - SEND: pll_cfg_req=1, with pll_cfg_addr=idx and pll_cfg_data=SHADOW[idx] held stable. On the cycle ack is sampled high, clear dirty[idx]. Then go to RST if idx=NUM_REGS−1, otherwise increment idx and return to SCAN.
  - RST: pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: a counter runs from 0. If synchronised lock=1, go to IDLE. If the counter reaches LOCK_TIMEOUT−1 without lock, set error and go to IDLE.
- START with no dirty registers still performs RST and WAIT_LOCK (forced relock).
- Busy, waitrequest mode: any access to any address gets mgmt_waitrequest=1 until the cycle after the FSM returns to IDLE. The access then completes normally.
- Busy, polling mode:
  - mgmt_waitrequest stays 0.
  - Reads complete; STATUS shows busy.
  - Writes to SHADOW and START are dropped.
  - MODE writes are accepted.
- Simultaneous read and write: the write is performed, and readdata is driven for the read address.
- pll_lock passes through a 2-flop synchroniser; the internal lock lags the pin by 2 cycles.
- No timeout on pll_cfg_ack: SEND waits indefinitely; mgmt_reset is the recovery path.

## Timing
- Reset values:
  - mgmt_readdata=0, mgmt_waitrequest=0.
  - pll_cfg_req=0, pll_cfg_addr=0, pll_cfg_data=0, pll_reset=0.
  - MODE=0, SHADOW all 0, dirty all 0, error=0, FSM=IDLE.
- Reset mid-sequence returns everything to these values on the next edge. req and pll_reset drop immediately, with no completion of the in-flight word.
- Reads: mgmt_readdata is a combinational mux of registered state. It is valid in any cycle with mgmt_read=1 and mgmt_waitrequest=0, and is 0 when mgmt_read=0.
- Writes take effect at the clock edge where mgmt_write=1 and mgmt_waitrequest=0.
- A START accepted at edge T gives busy=1 and FSM=SCAN visible from T+1.
- SEND: req rises the cycle after entering SEND. The cycle after ack is sampled, req=0. There is no back-to-back req without an intervening SCAN cycle.
- Sequence length: NUM_REGS SCAN cycles, plus for each dirty word (1 + ack latency + 1) cycles, plus RST_CYCLES, plus lock wait.
- The idx counter never wraps past NUM_REGS−1.

## Test plan
- Reset, then read 0x01 → 0x0. Write SHADOW[3]=0xA5A5_0003, read back → 0xA5A5_0003. Read 0x3F → 0.
- Write SHADOW[2] and SHADOW[9], then START; ack after 3 cycles each, lock high 20 cycles after RST → exactly two req transfers (addr 2 then 9, correct data), then pll_reset high exactly 8 cycles, then STATUS=0x2.
- Repeat START with no new writes → zero req transfers, one 8-cycle pll_reset pulse, then relock.
- LOCK_TIMEOUT=64, pll_lock held 0 → IDLE after 64 WAIT_LOCK cycles, STATUS=0x4. A new START clears bit2.
- MODE=1, write SHADOW[5]=0x55 mid-sequence → waitrequest stays 0, STATUS bit0=1, write dropped: SHADOW[5] unchanged, not dirty. MODE=0: a read during busy stalls until the cycle after IDLE.
- Assert mgmt_reset while in SEND with ack withheld → next cycle req=0, pll_reset=0, all shadows read 0, a subsequent START sends no words.
